// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: funct3 encodings, FSM states
// and the data width used by the responder, its interface and the load extender.
package dmem_responder_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;
    localparam logic [2:0] F3_SD = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Byte enables for an access of the given size, before shifting to the byte lane.
    function automatic logic [7:0] sizeMask(input logic [1:0] size);
        logic [7:0] mask;
        case ({1'b0, size})
            F3_SB:   mask = 8'h01;
            F3_SH:   mask = 8'h03;
            F3_SW:   mask = 8'h0F;
            F3_SD:   mask = 8'hFF;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
// Signal suffixes are written from the responder's point of view.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic            req_valid_i;
    logic            req_ready_o;
    logic [XLEN-1:0] req_addr_i;
    logic            req_store_i;
    logic [2:0]      req_funct3_i;
    logic [XLEN-1:0] req_wdata_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [XLEN-1:0] resp_rdata_o;
    logic            resp_err_o;

    modport master (
        output req_valid_i, req_addr_i, req_store_i, req_funct3_i, req_wdata_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_store_i, req_funct3_i, req_wdata_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

endinterface

// File: rtl/dmem_responder_load_extend.sv
// Picks the addressed bytes out of a 64-bit memory word and sign- or zero-extends
// them according to the load funct3. Little-endian: lane 0 is the low byte.
module load_extend
    import dmem_responder_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [2:0]      lane_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted  = word_i >> {lane_i, 3'b000};
        result_o = '0;
        case (funct3_i)
            F3_LB:   result_o = {{56{shifted[7]}}, shifted[7:0]};
            F3_LH:   result_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   result_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   result_o = shifted;
            F3_LBU:  result_o = {56'd0, shifted[7:0]};
            F3_LHU:  result_o = {48'd0, shifted[15:0]};
            F3_LWU:  result_o = {32'd0, shifted[31:0]};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the rv64IM load/store port: one request at a time, fixed
// access latency, byte/half/word/double accesses against an internal word array.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            store_q, store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] mem_q [DEPTH];

    logic            reqReady;
    logic            commit;
    logic            memWe;
    logic [XLEN-1:0] curAddr;
    logic [XLEN-1:0] curWdata;
    logic            curStore;
    logic [2:0]      curFunct3;
    logic [AW-1:0]   wordIdx;
    logic [2:0]      lane;
    logic            outOfRange;
    logic            misaligned;
    logic            illegal;
    logic            reqErr;
    logic [7:0]      byteEn;
    logic [XLEN-1:0] laneWdata;
    logic [XLEN-1:0] memWord;
    logic [XLEN-1:0] loadData;

    assign reqReady = (state_q == IDLE) && !reset;

    // With LATENCY=1 the commit happens on the accepting edge, so the request is
    // taken straight from the bus; otherwise it comes from the capture registers.
    assign curAddr   = (state_q == IDLE) ? bus.req_addr_i   : addr_q;
    assign curWdata  = (state_q == IDLE) ? bus.req_wdata_i  : wdata_q;
    assign curStore  = (state_q == IDLE) ? bus.req_store_i  : store_q;
    assign curFunct3 = (state_q == IDLE) ? bus.req_funct3_i : funct3_q;

    assign wordIdx   = curAddr[3 +: AW];
    assign lane      = curAddr[2:0];
    assign memWord   = mem_q[wordIdx];
    assign byteEn    = sizeMask(curFunct3[1:0]) << lane;
    assign laneWdata = curWdata << {lane, 3'b000};

    always_comb begin
        outOfRange = |curAddr[XLEN-1:3+AW];
        misaligned = 1'b0;
        case (curFunct3[1:0])
            2'd1:    misaligned = curAddr[0];
            2'd2:    misaligned = |curAddr[1:0];
            2'd3:    misaligned = |curAddr[2:0];
            default: misaligned = 1'b0;
        endcase
        illegal = curStore ? (curFunct3 > F3_SD) : (curFunct3 == 3'd7);
        reqErr  = outOfRange || misaligned || illegal;
    end

    load_extend u_loadExtend (
        .word_i   (memWord),
        .lane_i   (lane),
        .funct3_i (curFunct3),
        .result_o (loadData)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    addr_d   = bus.req_addr_i;
                    wdata_d  = bus.req_wdata_i;
                    store_d  = bus.req_store_i;
                    funct3_d = bus.req_funct3_i;
                    count_d  = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rdata_d = (curStore || reqErr) ? '0 : loadData;
            err_d   = reqErr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        store_q  <= store_d;
        funct3_q <= funct3_d;
    end

    // Reset at the commit edge must suppress the write: the request is being dropped.
    assign memWe = commit && curStore && !reqErr && !reset;

    always_ff @(posedge clock) begin
        if (memWe) begin
            for (int b = 0; b < 8; b++) begin
                if (byteEn[b]) begin
                    mem_q[wordIdx][8*b +: 8] <= laneWdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready_o  = reqReady;
    assign bus.resp_valid_o = (state_q == RESP);
    assign bus.resp_rdata_o = rdata_q;
    assign bus.resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 2, 3) driven by directed
// vectors and checked every cycle against a byte-array memory model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int NDUT  = 3;

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LD = 3'd3;
    localparam logic [2:0] LBU = 3'd4, LHU = 3'd5, LWU = 3'd6;

    logic        clock;
    logic        rst        [NDUT];
    logic        reqValid   [NDUT];
    logic        reqReady   [NDUT];
    logic [63:0] reqAddr    [NDUT];
    logic        reqStore   [NDUT];
    logic [2:0]  reqFunct3  [NDUT];
    logic [63:0] reqWdata   [NDUT];
    logic        respValid  [NDUT];
    logic        respReady  [NDUT];
    logic [63:0] respRdata  [NDUT];
    logic        respErr    [NDUT];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [7:0]  mdl [NDUT][DEPTH*8];

    logic        pendValid   [NDUT];
    logic        pendSeen    [NDUT];
    int          pendRise    [NDUT];
    logic        pendStore   [NDUT];
    logic [2:0]  pendFunct3  [NDUT];
    logic [63:0] pendAddr    [NDUT];
    logic [63:0] pendWdata   [NDUT];
    logic [63:0] pendData    [NDUT];
    logic        pendErr     [NDUT];
    logic [63:0] lastRdata   [NDUT];
    logic        lastErr     [NDUT];
    logic [63:0] lastExpData [NDUT];
    logic        lastExpErr  [NDUT];
    int          lastAcceptEdge [NDUT];
    int          lastHsEdge     [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        dmem_responder_if bus ();

        assign bus.req_valid_i  = reqValid[g];
        assign bus.req_addr_i   = reqAddr[g];
        assign bus.req_store_i  = reqStore[g];
        assign bus.req_funct3_i = reqFunct3[g];
        assign bus.req_wdata_i  = reqWdata[g];
        assign bus.resp_ready_i = respReady[g];
        assign reqReady[g]      = bus.req_ready_o;
        assign respValid[g]     = bus.resp_valid_o;
        assign respRdata[g]     = bus.resp_rdata_o;
        assign respErr[g]       = bus.resp_err_o;

        dmem_responder #(
            .DEPTH   (DEPTH),
            .LATENCY (g + 1)
        ) u_dut (
            .clock (clock),
            .reset (rst[g]),
            .bus   (bus)
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%016h expected=0x%016h", name, actual, expected);
        end
    endtask

    // Expected response from the architectural rules over a plain byte array.
    function automatic void modelExpect(input int k, input logic st, input logic [2:0] f3,
                                        input logic [63:0] a, output logic e, output logic [63:0] d);
        int size;
        logic [63:0] v;
        size = 1 << f3[1:0];
        e = 1'b0;
        d = '0;
        if (a >= 64'(DEPTH * 8)) e = 1'b1;
        if ((a % 64'(size)) != 0) e = 1'b1;
        if (!st && f3 == 3'd7) e = 1'b1;
        if (st && f3 > 3'd3) e = 1'b1;
        if (!e && !st) begin
            v = '0;
            for (int i = 0; i < size; i++) v = v | (64'(mdl[k][int'(a) + i]) << (8 * i));
            if (f3 < 3'd4 && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8 * size));
            d = v;
        end
    endfunction

    function automatic void modelWrite(input int k, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < size; i++) mdl[k][int'(a) + i] = wd[8*i +: 8];
    endfunction

    always @(negedge clock) begin
        for (int k = 0; k < NDUT; k++) begin
            if (rst[k]) begin
                pendValid[k] = 1'b0;
                checkOutput($sformatf("dut%0d_ready_in_reset", k), 64'(reqReady[k]), 64'd0);
            end else begin
                if (respValid[k]) begin
                    if (!pendValid[k]) begin
                        checkOutput($sformatf("dut%0d_unexpected_resp", k), 64'(respValid[k]), 64'd0);
                    end else begin
                        if (!pendSeen[k]) begin
                            checkOutput($sformatf("dut%0d_resp_latency", k), 64'(cycle), 64'(pendRise[k]));
                            pendSeen[k] = 1'b1;
                            if (pendStore[k] && !pendErr[k]) modelWrite(k, pendFunct3[k], pendAddr[k], pendWdata[k]);
                        end
                        checkOutput($sformatf("dut%0d_resp_rdata", k), respRdata[k], pendData[k]);
                        checkOutput($sformatf("dut%0d_resp_err", k), 64'(respErr[k]), 64'(pendErr[k]));
                        checkOutput($sformatf("dut%0d_ready_in_resp", k), 64'(reqReady[k]), 64'd0);
                        if (respReady[k]) begin
                            lastRdata[k]  = respRdata[k];
                            lastErr[k]    = respErr[k];
                            lastHsEdge[k] = cycle + 1;
                            pendValid[k]  = 1'b0;
                        end
                    end
                end else if (pendValid[k] && cycle >= pendRise[k]) begin
                    checkOutput($sformatf("dut%0d_resp_missing", k), 64'(respValid[k]), 64'd1);
                    pendValid[k] = 1'b0;
                end
                if (reqValid[k] && reqReady[k]) begin
                    modelExpect(k, reqStore[k], reqFunct3[k], reqAddr[k], pendErr[k], pendData[k]);
                    pendValid[k]      = 1'b1;
                    pendSeen[k]       = 1'b0;
                    pendRise[k]       = cycle + k + 1;
                    pendStore[k]      = reqStore[k];
                    pendFunct3[k]     = reqFunct3[k];
                    pendAddr[k]       = reqAddr[k];
                    pendWdata[k]      = reqWdata[k];
                    lastExpData[k]    = pendData[k];
                    lastExpErr[k]     = pendErr[k];
                    lastAcceptEdge[k] = cycle + 1;
                end
            end
        end
    end

    task automatic waitAccept(input int k);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (reqReady[k]) done = 1'b1;
        end
        checkOutput($sformatf("dut%0d_accept_in_time", k), 64'(done), 64'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic waitHandshake(input int k);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (respValid[k] && respReady[k]) done = 1'b1;
        end
        checkOutput($sformatf("dut%0d_handshake_in_time", k), 64'(done), 64'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic driveReq(input int k, input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        reqStore[k]  = st;
        reqFunct3[k] = f3;
        reqAddr[k]   = a;
        reqWdata[k]  = wd;
        reqValid[k]  = 1'b1;
    endtask

    task automatic applyStimulus(input int k, input string name, input logic st, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] wd,
                                 input logic [63:0] expRd, input logic expErr);
        driveReq(k, st, f3, a, wd);
        waitAccept(k);
        reqValid[k] = 1'b0;
        waitHandshake(k);
        checkOutput({name, "_rdata"}, lastRdata[k], expRd);
        checkOutput({name, "_err"}, 64'(lastErr[k]), 64'(expErr));
        checkOutput({name, "_model_rdata"}, lastExpData[k], expRd);
        checkOutput({name, "_model_err"}, 64'(lastExpErr[k]), 64'(expErr));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            rst[k]       = 1'b1;
            reqValid[k]  = 1'b0;
            reqAddr[k]   = '0;
            reqStore[k]  = 1'b0;
            reqFunct3[k] = '0;
            reqWdata[k]  = '0;
            respReady[k] = 1'b1;
            pendValid[k] = 1'b0;
            pendSeen[k]  = 1'b0;
            lastRdata[k] = '0;
            lastErr[k]   = 1'b0;
            lastExpData[k] = '0;
            lastExpErr[k]  = 1'b0;
            lastAcceptEdge[k] = 0;
            lastHsEdge[k]     = 0;
        end
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < DEPTH * 8; i++) mdl[k][i] = 8'h00;

        @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("dut%0d_reset_valid", k), 64'(respValid[k]), 64'd0);
            checkOutput($sformatf("dut%0d_reset_rdata", k), respRdata[k], 64'd0);
            checkOutput($sformatf("dut%0d_reset_err", k), 64'(respErr[k]), 64'd0);
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
        @(negedge clock);
        for (int k = 0; k < NDUT; k++)
            checkOutput($sformatf("dut%0d_ready_after_reset", k), 64'(reqReady[k]), 64'd1);
        @(posedge clock);
        #1;

        // LATENCY=1: commit from the live request on the accepting edge.
        applyStimulus(0, "l1_sd",    1'b1, LD,  64'h10, 64'h1122334455667788, 64'h0, 1'b0);
        applyStimulus(0, "l1_ld",    1'b0, LD,  64'h10, 64'h0, 64'h1122334455667788, 1'b0);
        applyStimulus(0, "l1_sb",    1'b1, LB,  64'h13, 64'hAB, 64'h0, 1'b0);
        applyStimulus(0, "l1_lbu",   1'b0, LBU, 64'h13, 64'h0, 64'hAB, 1'b0);
        applyStimulus(0, "l1_lw_mis",1'b0, LW,  64'h12, 64'h0, 64'h0, 1'b1);

        // LATENCY=2: main functional vectors.
        applyStimulus(1, "sd",       1'b1, LD,  64'h10, 64'h1122334455667788, 64'h0, 1'b0);
        applyStimulus(1, "ld",       1'b0, LD,  64'h10, 64'h0, 64'h1122334455667788, 1'b0);
        applyStimulus(1, "sb",       1'b1, LB,  64'h13, 64'h123456789ABCDEAB, 64'h0, 1'b0);
        applyStimulus(1, "lb",       1'b0, LB,  64'h13, 64'h0, 64'hFFFFFFFFFFFFFFAB, 1'b0);
        applyStimulus(1, "lbu",      1'b0, LBU, 64'h13, 64'h0, 64'h00000000000000AB, 1'b0);
        applyStimulus(1, "ld_merged",1'b0, LD,  64'h10, 64'h0, 64'h11223344AB667788, 1'b0);
        applyStimulus(1, "sw",       1'b1, LW,  64'h20, 64'hFFFFFFFF80000001, 64'h0, 1'b0);
        applyStimulus(1, "lw",       1'b0, LW,  64'h20, 64'h0, 64'hFFFFFFFF80000001, 1'b0);
        applyStimulus(1, "lwu",      1'b0, LWU, 64'h20, 64'h0, 64'h0000000080000001, 1'b0);
        applyStimulus(1, "lh",       1'b0, LH,  64'h22, 64'h0, 64'hFFFFFFFFFFFF8000, 1'b0);
        applyStimulus(1, "lhu",      1'b0, LHU, 64'h22, 64'h0, 64'h0000000000008000, 1'b0);
        applyStimulus(1, "lb_low",   1'b0, LB,  64'h20, 64'h0, 64'h0000000000000001, 1'b0);
        applyStimulus(1, "lw_mis",   1'b0, LW,  64'h12, 64'h0, 64'h0, 1'b1);
        applyStimulus(1, "sh_mis",   1'b1, LH,  64'h11, 64'hBEEF, 64'h0, 1'b1);
        applyStimulus(1, "ld_after", 1'b0, LD,  64'h10, 64'h0, 64'h11223344AB667788, 1'b0);
        applyStimulus(1, "ld_range", 1'b0, LD,  64'(DEPTH * 8), 64'h0, 64'h0, 1'b1);
        applyStimulus(1, "ld_high",  1'b0, LD,  64'h8000000000000010, 64'h0, 64'h0, 1'b1);
        applyStimulus(1, "load_f7",  1'b0, 3'd7, 64'h10, 64'h0, 64'h0, 1'b1);
        applyStimulus(1, "store_f4", 1'b1, 3'd4, 64'h10, 64'hFF, 64'h0, 1'b1);
        applyStimulus(1, "sd_top",   1'b1, LD,  64'(DEPTH * 8 - 8), 64'hCAFEF00D12345678, 64'h0, 1'b0);
        applyStimulus(1, "ld_top",   1'b0, LD,  64'(DEPTH * 8 - 8), 64'h0, 64'hCAFEF00D12345678, 1'b0);
        applyStimulus(1, "ld_ok",    1'b0, LD,  64'h10, 64'h0, 64'h11223344AB667788, 1'b0);

        // Backpressure: response held while the next request waits on the bus.
        respReady[1] = 1'b0;
        driveReq(1, 1'b0, LD, 64'h10, 64'h0);
        waitAccept(1);
        driveReq(1, 1'b0, LBU, 64'h13, 64'h0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clock);
                if (respValid[1]) seen = 1'b1;
            end
            checkOutput("bp_resp_seen", 64'(seen), 64'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("bp_valid_held", 64'(respValid[1]), 64'd1);
            checkOutput("bp_rdata_stable", respRdata[1], 64'h11223344AB667788);
            checkOutput("bp_ready_low", 64'(reqReady[1]), 64'd0);
        end
        @(posedge clock);
        #1;
        respReady[1] = 1'b1;
        waitAccept(1);
        reqValid[1] = 1'b0;
        checkOutput("bp_first_rdata", lastRdata[1], 64'h11223344AB667788);
        checkOutput("bp_accept_spacing", 64'(lastAcceptEdge[1]), 64'(lastHsEdge[1] + 1));
        waitHandshake(1);
        checkOutput("bp_second_rdata", lastRdata[1], 64'h00000000000000AB);

        // LATENCY=3: a store dropped by reset in WAIT must leave memory untouched.
        applyStimulus(2, "l3_sd_prior", 1'b1, LD, 64'h28, 64'h0123456789ABCDEF, 64'h0, 1'b0);
        driveReq(2, 1'b1, LD, 64'h28, 64'hDEAD);
        waitAccept(2);
        reqValid[2] = 1'b0;
        rst[2] = 1'b1;
        @(posedge clock);
        #1;
        rst[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checkOutput("l3_dropped_no_resp", 64'(respValid[2]), 64'd0);
        end
        @(posedge clock);
        #1;
        applyStimulus(2, "l3_ld_prior", 1'b0, LD, 64'h28, 64'h0, 64'h0123456789ABCDEF, 1'b0);

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
